// File: rtl/bpred_pkg.sv
// Shared types and helpers for the branch predictor pattern history table.
//   ctr_t      : 2-bit saturating direction counter
//   SNT..ST    : counter encodings (strong/weak not-taken, weak/strong taken)
//   state_t    : controller FSM states (INIT sweep, RUN)
//   ctr_next() : counter next-state for a resolved branch outcome
package bpred_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A not-taken outcome from weakly-taken drops straight to strongly
    // not-taken; every case stays within the 2-bit encoding.
    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        if (taken) begin
            case (ctr)
                SNT:     nxt = WNT;
                WNT:     nxt = WT;
                WT:      nxt = ST;
                ST:      nxt = ST;
                default: nxt = WNT;
            endcase
        end else begin
            case (ctr)
                ST:      nxt = WT;
                WT:      nxt = SNT;
                WNT:     nxt = SNT;
                SNT:     nxt = SNT;
                default: nxt = SNT;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bpred_ctr_update.sv
// Combinational next-state for one 2-bit branch counter.
// Ports:
//   ctr      in  current counter value
//   taken    in  resolved branch outcome
//   ctr_nxt  out updated counter value
module bpred_ctr_update
    import bpred_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_nxt
);

    assign ctr_nxt = ctr_next(ctr, taken);

endmodule

// File: rtl/bpred_table_ctrl.sv
// Pattern history table controller: sweeps the table to INIT_STATE after
// reset, then serves one lookup per cycle (1-cycle latency) and applies
// resolved-branch updates through a 2-stage read-modify-write pipeline
// with forwarding between back-to-back updates to the same index.
// Optional feature macro: BPRED_BYPASS_EN -- when defined, a lookup that
// hits the entry being written in the same cycle sees the new value
// (write-first); otherwise it sees the old value (read-first).
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   pred_req/pred_idx    lookup request and index
//   pred_ready           lookups accepted (RUN only)
//   pred_valid/pred_taken registered lookup result, bit 1 of the counter
//   upd_valid/upd_idx/upd_taken  resolved-branch update
//   upd_ready            updates accepted (RUN only)
//   busy                 high during the INIT sweep
module bpred_table_ctrl
    import bpred_pkg::*;
#(
    parameter int   INDEX_W    = 4,
    parameter ctr_t INIT_STATE = 2'b01
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pred_req,
    input  logic [INDEX_W-1:0] pred_idx,
    output logic               pred_ready,
    output logic               pred_valid,
    output logic               pred_taken,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_idx,
    input  logic               upd_taken,
    output logic               upd_ready,
    output logic               busy
);

    localparam int ENTRIES = 2 ** INDEX_W;

    ctr_t               table_r [ENTRIES];
    state_t             state_r;
    state_t             state_next_s;
    logic [INDEX_W-1:0] sweep_r;
    logic               sweep_last_s;
    logic               busy_r;
    logic               ready_r;
    logic               pred_valid_r;
    logic               pred_taken_r;
    logic               upd_fire_s;
    ctr_t               s1_rd_s;
    ctr_t               lookup_s;
    logic               s2_valid_r;
    logic [INDEX_W-1:0] s2_idx_r;
    logic               s2_taken_r;
    ctr_t               s2_ctr_r;
    ctr_t               s2_next_s;

    assign sweep_last_s = (sweep_r == INDEX_W'(ENTRIES - 1));
    assign upd_fire_s   = upd_valid & ready_r;

    assign pred_ready = ready_r;
    assign upd_ready  = ready_r;
    assign busy       = busy_r;
    assign pred_valid = pred_valid_r;
    assign pred_taken = pred_taken_r;

    bpred_ctr_update u_ctr_update (
        .ctr     (s2_ctr_r),
        .taken   (s2_taken_r),
        .ctr_nxt (s2_next_s)
    );

    // FSM next state: INIT advances to RUN once the last entry is written.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            INIT: begin
                if (sweep_last_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = INIT;
                end
            end
            RUN:     state_next_s = RUN;
            default: state_next_s = INIT;
        endcase
    end

    // S1 read: forward the in-flight S2 result so same-index updates compound.
    always_comb begin
        s1_rd_s = table_r[upd_idx];
        if (s2_valid_r && (s2_idx_r == upd_idx)) begin
            s1_rd_s = s2_next_s;
        end else begin
            s1_rd_s = table_r[upd_idx];
        end
    end

    // Lookup read with optional write-first bypass of the S2 write.
    always_comb begin
        lookup_s = table_r[pred_idx];
`ifdef BPRED_BYPASS_EN
        if (s2_valid_r && (s2_idx_r == pred_idx)) begin
            lookup_s = s2_next_s;
        end else begin
            lookup_s = table_r[pred_idx];
        end
`else
        lookup_s = table_r[pred_idx];
`endif
    end

    // Control state, registered outputs and the update pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= INIT;
            sweep_r      <= {INDEX_W{1'b0}};
            busy_r       <= 1'b1;
            ready_r      <= 1'b0;
            pred_valid_r <= 1'b0;
            pred_taken_r <= 1'b0;
            s2_valid_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_r == INIT) begin
                sweep_r <= sweep_r + INDEX_W'(1);
            end else begin
                sweep_r <= sweep_r;
            end
            busy_r       <= (state_next_s == INIT);
            ready_r      <= (state_next_s == RUN);
            pred_valid_r <= ready_r & pred_req;
            pred_taken_r <= (ready_r & pred_req) ? lookup_s[1] : 1'b0;
            s2_valid_r   <= upd_fire_s;
            if (upd_fire_s) begin
                s2_idx_r   <= upd_idx;
                s2_taken_r <= upd_taken;
                s2_ctr_r   <= s1_rd_s;
            end
        end
    end

    // Table writes: INIT sweep, or the S2 write-back; reset drops a pending write.
    always_ff @(posedge clk) begin
        if (!rst && (state_r == INIT)) begin
            table_r[sweep_r] <= INIT_STATE;
        end else if (!rst && s2_valid_r) begin
            table_r[s2_idx_r] <= s2_next_s;
        end
    end

endmodule

// File: tb/tb_bpred_table_ctrl.sv
// Self-checking bench for bpred_table_ctrl: directed scenarios followed by
// a randomized request/update mix. A reference model of the table (plain
// integer counters, updates applied in acceptance order) predicts every
// lookup result; expected results are queued and a negedge monitor
// compares them with the DUT as pred_valid pulses appear.
module tb_bpred_table_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pred_req;
    logic [3:0] pred_idx;
    logic       pred_ready;
    logic       pred_valid;
    logic       pred_taken;
    logic       upd_valid;
    logic [3:0] upd_idx;
    logic       upd_taken;
    logic       upd_ready;
    logic       busy;

    always #5 clk = ~clk;

    bpred_table_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .pred_req   (pred_req),
        .pred_idx   (pred_idx),
        .pred_ready (pred_ready),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken),
        .upd_ready  (upd_ready),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;

    bit exp_q[$];
    int model[16];
    int init_left = 16;
    bit run       = 1'b0;
    bit pend_v    = 1'b0;
    int pend_idx  = 0;
    bit pend_tak  = 1'b0;
    int look_v;
    bit exp_bit;

    // Saturating counter rule: taken counts up to 3; not taken from 3 gives 2, otherwise 0.
    function automatic int ref_next(input int c, input bit t);
        if (t) return (c < 3) ? c + 1 : 3;
        else   return (c == 3) ? 2 : 0;
    endfunction

    // Reference model, stepped on every rising edge with the sampled inputs.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) model[i] = 1;
            pend_v    = 1'b0;
            init_left = 16;
            run       = 1'b0;
        end else if (run) begin
            if (pred_req) begin
                look_v = model[pred_idx];
`ifdef BPRED_BYPASS_EN
                if (pend_v && (pend_idx == int'(pred_idx)))
                    look_v = ref_next(model[pend_idx], pend_tak);
`endif
                exp_q.push_back(look_v >= 2);
            end
            if (pend_v) model[pend_idx] = ref_next(model[pend_idx], pend_tak);
            pend_v   = upd_valid;
            pend_idx = int'(upd_idx);
            pend_tak = upd_taken;
        end else begin
            init_left = init_left - 1;
            if (init_left == 0) run = 1'b1;
        end
    end

    // Monitor: status flags every cycle, lookup results against the queue.
    always @(negedge clk) begin
        checks++;
        if ({busy, pred_ready, upd_ready} !== {~run, run, run}) begin
            failures++;
            $display("FAIL status t=%0t busy/pred_ready/upd_ready got=%b%b%b exp=%b%b%b",
                     $time, busy, pred_ready, upd_ready, ~run, run, run);
        end
        checks++;
        if (pred_valid !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL pred_valid t=%0t got=%b exp=%b", $time, pred_valid, exp_q.size() != 0);
            exp_q.delete();
        end else if (pred_valid) begin
            exp_bit = exp_q.pop_front();
            checks++;
            if (pred_taken !== exp_bit) begin
                failures++;
                $display("FAIL pred_taken t=%0t idx_hist got=%b exp=%b", $time, pred_taken, exp_bit);
            end
        end
    end

    task automatic cyc(input bit r, input bit pq, input int pi,
                       input bit uv, input int ui, input bit ut);
        rst       = r;
        pred_req  = pq;
        pred_idx  = 4'(pi);
        upd_valid = uv;
        upd_idx   = 4'(ui);
        upd_taken = ut;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; pred_req = 1'b0; pred_idx = 4'd0;
        upd_valid = 1'b0; upd_idx = 4'd0; upd_taken = 1'b0;

        // Reset, INIT sweep, then every entry reads weakly not-taken.
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        idle(16);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, i, 1'b0, 0, 1'b0);
        idle(2);

        // idx 3: taken x2, then not-taken x2 with lookups in between.
        cyc(1'b0, 1'b0, 0, 1'b1, 3, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b1, 3, 1'b1);
        idle(2);
        cyc(1'b0, 1'b1, 3, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b1, 3, 1'b0);
        idle(2);
        cyc(1'b0, 1'b1, 3, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b1, 3, 1'b0);
        idle(2);
        cyc(1'b0, 1'b1, 3, 1'b0, 0, 1'b0);

        // idx 5: back-to-back taken x3, then a not-taken exposes 11 vs a stale 10.
        cyc(1'b0, 1'b0, 0, 1'b1, 5, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b1, 5, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b1, 5, 1'b1);
        idle(2);
        cyc(1'b0, 1'b1, 5, 1'b1, 5, 1'b0);
        idle(2);
        cyc(1'b0, 1'b1, 5, 1'b0, 0, 1'b0);

        // idx 7: lookup collides with the S2 write, then a clean lookup.
        cyc(1'b0, 1'b0, 0, 1'b1, 7, 1'b1);
        cyc(1'b0, 1'b1, 7, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b1, 7, 1'b0, 0, 1'b0);
        idle(2);

        // idx 2 update accepted, reset before its write; lookups during INIT ignored.
        cyc(1'b0, 1'b0, 0, 1'b1, 2, 1'b1);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, i, 1'b1, 2, 1'b1);
        cyc(1'b0, 1'b1, 2, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b1, 7, 1'b0, 0, 1'b0);
        idle(2);

        // Randomized mix, indices biased to a small set to provoke hazards.
        for (int n = 0; n < 2000; n++) begin
            cyc(($urandom_range(0, 999) == 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)));
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
